fsgnj_pipe: RTL and testbench
=============================

FSGNJ_PIPE -- requirements
Module: fsgnj_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, meaning exponent width.
REQ-002 SHALL have parameter MAN_W, default 23, meaning mantissa width (minimum 2).
REQ-003 SHALL have parameter DEPTH, default 2, meaning pipeline stages (legal 1..4).
REQ-004 SHALL have parameter TAG_W, default 5, meaning width of the sideband tag carried with each operation.
REQ-005 SHALL define W = 1+EXP_W+MAN_W as the operand width.
REQ-006 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port in_valid  input  1  request present.
REQ-009 SHALL have port in_ready  output  1  block accepts request this cycle.
REQ-010 SHALL have port x1  input  W  magnitude/exponent source operand.
REQ-011 SHALL have port x2  input  W  sign source operand.
REQ-012 SHALL have port mode  input  2  00 SGNJ, 01 SGNJN, 10 SGNJX, 11 MOVE.
REQ-013 SHALL have port in_tag  input  TAG_W  sideband tag.
REQ-014 SHALL have port out_valid  output  1  result present.
REQ-015 SHALL have port out_ready  input  1  consumer accepts result.
REQ-016 SHALL have port y  output  W  result.
REQ-017 SHALL have port exception  output  1  NaN-input flag for the result on y.
REQ-018 SHALL have port out_tag  output  TAG_W  tag of the result on y.
REQ-019 SHALL have port nan_count  output  16  saturating count of accepted ops that raised exception.
REQ-020 SHALL have port nan_clear  input  1  clears nan_count.

Function
REQ-021 SHALL accept an operation when in_valid && in_ready, and SHALL complete it when out_valid && out_ready.
REQ-022 SHALL place each result on the output exactly DEPTH cycles after acceptance when no stall occurs, giving throughput of one op per cycle.
REQ-023 SHALL advance each stage register only when the next stage is empty or advancing, where the last stage advances on out_ready.
REQ-024 SHALL drive in_ready = !stage0_valid || stage0_advances, combinationally and without a combinational path from in_valid.
REQ-025 SHALL hold y, exception and out_tag stable while out_valid && !out_ready.
REQ-026 SHALL return results in acceptance order, never dropping or duplicating an op.
REQ-027 SHALL treat an operand as NaN when exponent is all ones and mantissa is nonzero; infinities and zeros are not NaN.
REQ-028 SHALL output {s1, all-ones, 1, m1[MAN_W-2:0]} with exception=1 when x1 is NaN, regardless of mode.
REQ-029 SHALL output {s2, all-ones, 1, m2[MAN_W-2:0]} with exception=1 when x1 is not NaN and x2 is NaN.
REQ-030 SHALL otherwise output {sign, e1, m1} with exception=0, where sign is s2 (mode 00), ~s2 (01), s1^s2 (10) or s1 (11).
REQ-031 SHALL compute the result in stage 0, with later stages pure delay; out_tag SHALL equal the in_tag of the same op.
REQ-032 SHALL increment nan_count by 1 when an op with exception=1 completes, saturating at 16'hFFFF.
REQ-033 SHALL zero nan_count when nan_clear is high, taking priority over a simultaneous increment.

Reset
REQ-034 SHALL, while rst is high, clear all stage valid bits and force out_valid=0, nan_count=0, and in_ready=0.
REQ-035 SHALL discard all in-flight ops when rst is asserted mid-operation, with no completion after reset.
REQ-036 SHALL drive in_ready=1 in the first cycle after rst deasserts.
REQ-037 SHALL clear all data and tag registers to 0 on reset, so y=0, exception=0 and out_tag=0 out of reset.

Verification
REQ-038 Bench SHALL cover: defaults, out_ready=1, x1=32'h3F800000, x2=32'h80000000, mode=00, 01, 10, 11 back to back, giving 32'hBF800000, 32'h3F800000, 32'hBF800000, 32'h3F800000 on consecutive cycles, each arriving 2 cycles after its input.
REQ-039 Bench SHALL cover: x1=32'h7F800001, x2=32'h7FC00000, giving y=32'h7FC00001, exception=1 and nan_count=1; x1=32'hFF800000 (-inf), x2=32'h00000000, mode 00, giving 32'h7F800000, exception=0.
REQ-040 Bench SHALL cover: out_ready=0 for 5 cycles with continuous in_valid, giving in_ready=0 after DEPTH accepts, y held stable, then in-order drain with no loss once out_ready=1.
REQ-041 Bench SHALL cover: rst asserted with 2 ops in flight, giving out_valid=0 the next cycle, nan_count=0, and none of those ops emitted afterwards.
REQ-042 Bench SHALL cover: nan_count preloaded to 16'hFFFF by 65535 NaN ops, then one more NaN op, giving it held at 16'hFFFF; nan_clear together with a NaN completion, giving 0.
REQ-043 Bench SHALL cover: EXP_W=11, MAN_W=52, DEPTH=1, x1=64'h4000000000000000, x2=64'h8000000000000000, mode 10, giving 64'hC000000000000000 one cycle later.

Source files
------------

// File: rtl/fsgnj_pipe.sv
// fsgnj_pipe: pipelined floating-point sign-injection unit (SGNJ/SGNJN/SGNJX/MOVE)
// with NaN detection, a valid/ready handshake on both sides, a sideband tag
// carried with each op, and a saturating count of completed NaN results.
// The result is formed in stage 0; the remaining stages only delay it.
module fsgnj_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int DEPTH = 2,
    parameter int TAG_W = 5,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     x1,
    input  logic [W-1:0]     x2,
    input  logic [1:0]       mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     y,
    output logic             exception,
    output logic [TAG_W-1:0] out_tag,
    output logic [15:0]      nan_count,
    input  logic             nan_clear
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [W-1:0]     data_q [DEPTH];
    logic [W-1:0]     data_d [DEPTH];
    logic [DEPTH-1:0] exc_q, exc_d;
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [TAG_W-1:0] tag_d [DEPTH];
    logic [DEPTH-1:0] load;
    logic [15:0]      nan_count_q, nan_count_d;

    logic             s1, s2, sel_sign, nan1, nan2, res_exc;
    logic [EXP_W-1:0] e1, e2;
    logic [MAN_W-1:0] m1, m2;
    logic [W-1:0]     res_y;

    // A stage may take new contents when it, or any stage after it, is empty,
    // or when the consumer is draining the last stage. This closed form avoids
    // a ripple chain of per-stage "advancing" signals.
    function automatic logic [DEPTH-1:0] calc_load(input logic [DEPTH-1:0] v,
                                                   input logic rdy);
        logic full;
        logic [DEPTH-1:0] ld;
        ld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            full = 1'b1;
            for (int j = i; j < DEPTH; j++) begin
                full = full & v[j];
            end
            ld[i] = rdy | ~full;
        end
        return ld;
    endfunction

    // Stage-0 datapath: split fields, detect NaNs, choose the injected sign.
    always_comb begin
        s1 = x1[W-1];
        e1 = x1[W-2:MAN_W];
        m1 = x1[MAN_W-1:0];
        s2 = x2[W-1];
        e2 = x2[W-2:MAN_W];
        m2 = x2[MAN_W-1:0];
        nan1 = (&e1) && (|m1);
        nan2 = (&e2) && (|m2);
        case (mode)
            2'b00:   sel_sign = s2;
            2'b01:   sel_sign = ~s2;
            2'b10:   sel_sign = s1 ^ s2;
            default: sel_sign = s1;
        endcase
        res_y   = {sel_sign, e1, m1};
        res_exc = 1'b0;
        if (nan1) begin
            res_y   = {s1, {EXP_W{1'b1}}, 1'b1, m1[MAN_W-2:0]};
            res_exc = 1'b1;
        end else if (nan2) begin
            res_y   = {s2, {EXP_W{1'b1}}, 1'b1, m2[MAN_W-2:0]};
            res_exc = 1'b1;
        end
    end

    // Per-stage load enables; in_ready depends only on pipeline state and rst.
    always_comb begin
        load     = calc_load(valid_q, out_ready);
        in_ready = !rst && load[0];
    end

    // Next-state of the pipeline: payload only moves when the source is valid,
    // so a stalled output keeps its data and bubbles never overwrite results.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        exc_d   = exc_q;
        tag_d   = tag_q;
        if (load[0]) begin
            valid_d[0] = in_valid;
            if (in_valid) begin
                data_d[0] = res_y;
                exc_d[0]  = res_exc;
                tag_d[0]  = in_tag;
            end
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (load[i]) begin
                valid_d[i] = valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_d[i] = data_q[i-1];
                    exc_d[i]  = exc_q[i-1];
                    tag_d[i]  = tag_q[i-1];
                end
            end
        end
    end

    // NaN counter: clear wins over a completing NaN; saturates at all ones.
    always_comb begin
        nan_count_d = nan_count_q;
        if (nan_clear) begin
            nan_count_d = 16'h0000;
        end else if (valid_q[DEPTH-1] && out_ready && exc_q[DEPTH-1]
                     && (nan_count_q != 16'hFFFF)) begin
            nan_count_d = nan_count_q + 16'h0001;
        end
    end

    // State registers with synchronous reset clearing valid, payload and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            exc_q       <= '0;
            nan_count_q <= 16'h0000;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            exc_q       <= exc_d;
            nan_count_q <= nan_count_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
                tag_q[i]  <= tag_d[i];
            end
        end
    end

    // Output view of the last stage; out_valid is held low during reset.
    always_comb begin
        out_valid = valid_q[DEPTH-1] && !rst;
        y         = data_q[DEPTH-1];
        exception = exc_q[DEPTH-1];
        out_tag   = tag_q[DEPTH-1];
        nan_count = nan_count_q;
    end

endmodule

// File: tb/tb_fsgnj_pipe.sv
// tb_fsgnj_pipe: directed self-checking bench for fsgnj_pipe. A default
// 32-bit, two-stage instance carries most scenarios; a 64-bit, one-stage
// instance covers the wide configuration.
module tb_fsgnj_pipe;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, out_valid, out_ready, exception, nan_clear;
    logic [31:0] x1, x2, y;
    logic [1:0]  mode;
    logic [4:0]  in_tag, out_tag;
    logic [15:0] nan_count;

    logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w, exception_w, nan_clear_w;
    logic [63:0] x1_w, x2_w, y_w;
    logic [1:0]  mode_w;
    logic [4:0]  in_tag_w, out_tag_w;
    logic [15:0] nan_count_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fsgnj_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .x1(x1), .x2(x2), .mode(mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .exception(exception), .out_tag(out_tag),
        .nan_count(nan_count), .nan_clear(nan_clear)
    );

    fsgnj_pipe #(.EXP_W(11), .MAN_W(52), .DEPTH(1), .TAG_W(5)) dut_w (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_w), .in_ready(in_ready_w),
        .x1(x1_w), .x2(x2_w), .mode(mode_w), .in_tag(in_tag_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w),
        .y(y_w), .exception(exception_w), .out_tag(out_tag_w),
        .nan_count(nan_count_w), .nan_clear(nan_clear_w)
    );

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a cycle, then wait (bounded) until it reaches the output.
    task automatic issue_op(input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] m, input logic [4:0] t,
                            output logic got, output logic [31:0] gy,
                            output logic ge, output logic [4:0] gt);
        in_valid = 1'b1;
        x1 = a; x2 = b; mode = m; in_tag = t;
        step();
        in_valid = 1'b0;
        got = 1'b0; gy = '0; ge = 1'b0; gt = '0;
        for (int k = 0; k < 10; k++) begin
            if (!got) begin
                if (out_valid) begin
                    got = 1'b1; gy = y; ge = exception; gt = out_tag;
                end else begin
                    step();
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; x1 = '0; x2 = '0; mode = 2'b00; in_tag = '0;
        out_ready = 1'b0; nan_clear = 1'b0;
        in_valid_w = 1'b0; x1_w = '0; x2_w = '0; mode_w = 2'b00; in_tag_w = '0;
        out_ready_w = 1'b0; nan_clear_w = 1'b0;
        step();
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_checks++;
        if (nan_count !== 16'h0000) begin n_fail++; $display("FAIL reset_nan_count: got %h expected 0000", nan_count); end
        n_checks++;
        if ({y, exception, out_tag} !== 38'h0) begin n_fail++; $display("FAIL reset_payload: got y=%h exc=%b tag=%h expected zeros", y, exception, out_tag); end
        n_checks++;
        if (out_valid_w !== 1'b0) begin n_fail++; $display("FAIL reset_wide_out_valid: got %b expected 0", out_valid_w); end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); end
        n_checks++;
        if (in_ready_w !== 1'b1) begin n_fail++; $display("FAIL reset_release_wide_in_ready: got %b expected 1", in_ready_w); end
    endtask

    task automatic test_sign_modes();
        logic [31:0] exp_y [4];
        exp_y[0] = 32'hBF800000;
        exp_y[1] = 32'h3F800000;
        exp_y[2] = 32'hBF800000;
        exp_y[3] = 32'h3F800000;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                in_valid = 1'b1; x1 = 32'h3F800000; x2 = 32'h80000000;
                mode = 2'(c); in_tag = 5'(c + 1);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (c == 0 || c == 5) begin
                n_checks++;
                if (out_valid !== 1'b0) begin n_fail++; $display("FAIL modes_latency c=%0d: got out_valid=%b expected 0", c, out_valid); end
            end else begin
                n_checks++;
                if (out_valid !== 1'b1 || y !== exp_y[c-1] || out_tag !== 5'(c)) begin
                    n_fail++;
                    $display("FAIL modes_result mode=%0d: got v=%b y=%h tag=%0d expected v=1 y=%h tag=%0d",
                             c - 1, out_valid, y, out_tag, exp_y[c-1], c);
                end
            end
        end
    endtask

    task automatic test_nan_inputs();
        logic got, ge;
        logic [31:0] gy;
        logic [4:0] gt;
        out_ready = 1'b1;
        issue_op(32'h7F800001, 32'h7FC00000, 2'b10, 5'd7, got, gy, ge, gt);
        n_checks++;
        if (!got || gy !== 32'h7FC00001 || ge !== 1'b1 || gt !== 5'd7) begin
            n_fail++; $display("FAIL nan_x1: got v=%b y=%h exc=%b tag=%0d expected v=1 y=7fc00001 exc=1 tag=7", got, gy, ge, gt);
        end
        step();
        n_checks++;
        if (nan_count !== 16'd1) begin n_fail++; $display("FAIL nan_count_first: got %0d expected 1", nan_count); end

        issue_op(32'hFF800000, 32'h00000000, 2'b00, 5'd8, got, gy, ge, gt);
        n_checks++;
        if (!got || gy !== 32'h7F800000 || ge !== 1'b0 || gt !== 5'd8) begin
            n_fail++; $display("FAIL inf_not_nan: got v=%b y=%h exc=%b tag=%0d expected v=1 y=7f800000 exc=0 tag=8", got, gy, ge, gt);
        end
        step();
        n_checks++;
        if (nan_count !== 16'd1) begin n_fail++; $display("FAIL nan_count_after_inf: got %0d expected 1", nan_count); end

        issue_op(32'h3F800000, 32'hFF800005, 2'b11, 5'd9, got, gy, ge, gt);
        n_checks++;
        if (!got || gy !== 32'hFFC00005 || ge !== 1'b1 || gt !== 5'd9) begin
            n_fail++; $display("FAIL nan_x2: got v=%b y=%h exc=%b tag=%0d expected v=1 y=ffc00005 exc=1 tag=9", got, gy, ge, gt);
        end
        step();
        n_checks++;
        if (nan_count !== 16'd2) begin n_fail++; $display("FAIL nan_count_second: got %0d expected 2", nan_count); end
    endtask

    task automatic test_back_to_back_stall();
        int sent = 0;
        int rcv  = 0;
        logic acc;
        logic [31:0] held_y, exp_v;
        for (int c = 0; c < 40; c++) begin
            out_ready = (c >= 5);
            in_valid  = (sent < 6);
            x1 = 32'h40000000 + (32'(sent) << 23);
            x2 = sent[0] ? 32'h80000000 : 32'h00000000;
            mode = 2'b00;
            in_tag = 5'(sent);
            #1;
            acc = in_valid && in_ready;
            if (c == 2) begin
                held_y = y;
                n_checks++;
                if (out_valid !== 1'b1 || y !== 32'h40000000) begin
                    n_fail++; $display("FAIL stall_head: got v=%b y=%h expected v=1 y=40000000", out_valid, y);
                end
            end
            if (c == 3 || c == 4) begin
                n_checks++;
                if (y !== held_y || out_tag !== 5'd0 || out_valid !== 1'b1) begin
                    n_fail++; $display("FAIL stall_hold c=%0d: got v=%b y=%h tag=%0d expected v=1 y=%h tag=0", c, out_valid, y, out_tag, held_y);
                end
            end
            if (c == 4) begin
                n_checks++;
                if (in_ready !== 1'b0 || sent != 2) begin
                    n_fail++; $display("FAIL stall_full: got in_ready=%b accepted=%0d expected in_ready=0 accepted=2", in_ready, sent);
                end
            end
            if (out_valid && out_ready) begin
                exp_v = (32'h40000000 + (32'(rcv) << 23)) | (rcv[0] ? 32'h80000000 : 32'h0);
                n_checks++;
                if (y !== exp_v || out_tag !== 5'(rcv)) begin
                    n_fail++; $display("FAIL drain_order idx=%0d: got y=%h tag=%0d expected y=%h tag=%0d", rcv, y, out_tag, exp_v, rcv);
                end
                rcv++;
            end
            step();
            if (acc) sent++;
        end
        n_checks++;
        if (rcv != 6 || sent != 6) begin n_fail++; $display("FAIL drain_count: got sent=%0d received=%0d expected 6 and 6", sent, rcv); end
    endtask

    task automatic test_reset_midflight();
        logic seen = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1; x1 = 32'h7F800001; x2 = 32'h0; mode = 2'b00; in_tag = 5'd20;
        step();
        in_tag = 5'd21;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL midflight_setup: got out_valid=%b in_ready=%b expected 1 and 0", out_valid, in_ready);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || nan_count !== 16'd0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL midflight_reset: got out_valid=%b nan_count=%0d in_ready=%b expected 0 0 0", out_valid, nan_count, in_ready);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL midflight_leak: got a result after reset expected none"); end
    endtask

    task automatic test_nan_saturation();
        int sent = 0;
        logic acc, got, ge;
        logic [31:0] gy;
        logic [4:0] gt;
        out_ready = 1'b1;
        nan_clear = 1'b0;
        in_valid = 1'b1; x1 = 32'h7F800001; x2 = 32'h0; mode = 2'b00; in_tag = 5'd1;
        for (int c = 0; c < 70000; c++) begin
            if (sent < 65535) begin
                acc = in_ready;
                if (sent == 65534) begin
                    step();
                    in_valid = 1'b0;
                end else begin
                    step();
                end
                if (acc) sent++;
            end
        end
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) step();
        n_checks++;
        if (sent != 65535 || nan_count !== 16'hFFFF) begin
            n_fail++; $display("FAIL sat_preload: got accepted=%0d nan_count=%h expected 65535 ffff", sent, nan_count);
        end
        issue_op(32'h7F800001, 32'h0, 2'b00, 5'd2, got, gy, ge, gt);
        step();
        n_checks++;
        if (!got || nan_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got v=%b nan_count=%h expected v=1 ffff", got, nan_count); end
        issue_op(32'h7F800001, 32'h0, 2'b00, 5'd3, got, gy, ge, gt);
        nan_clear = 1'b1;
        step();
        nan_clear = 1'b0;
        n_checks++;
        if (!got || nan_count !== 16'h0000) begin n_fail++; $display("FAIL clear_priority: got v=%b nan_count=%h expected v=1 0000", got, nan_count); end
        issue_op(32'hFFFFFFFF, 32'h0, 2'b01, 5'd4, got, gy, ge, gt);
        step();
        n_checks++;
        if (!got || gy !== 32'hFFFFFFFF || nan_count !== 16'd1) begin
            n_fail++; $display("FAIL count_resume: got v=%b y=%h nan_count=%0d expected v=1 y=ffffffff 1", got, gy, nan_count);
        end
    endtask

    task automatic test_wide();
        out_ready_w = 1'b1;
        in_valid_w = 1'b1; x1_w = 64'h4000000000000000; x2_w = 64'h8000000000000000;
        mode_w = 2'b10; in_tag_w = 5'd3;
        #1;
        n_checks++;
        if (out_valid_w !== 1'b0) begin n_fail++; $display("FAIL wide_pre: got out_valid=%b expected 0", out_valid_w); end
        step();
        in_valid_w = 1'b0;
        n_checks++;
        if (out_valid_w !== 1'b1 || y_w !== 64'hC000000000000000 || exception_w !== 1'b0 || out_tag_w !== 5'd3) begin
            n_fail++; $display("FAIL wide_result: got v=%b y=%h exc=%b tag=%0d expected v=1 y=c000000000000000 exc=0 tag=3",
                               out_valid_w, y_w, exception_w, out_tag_w);
        end
        step();
        n_checks++;
        if (out_valid_w !== 1'b0) begin n_fail++; $display("FAIL wide_post: got out_valid=%b expected 0", out_valid_w); end
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        test_reset();
        test_sign_modes();
        test_nan_inputs();
        test_back_to_back_stall();
        test_reset_midflight();
        test_nan_saturation();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net so a stuck run still terminates.
    initial begin
        #5000000;
        $display("FAIL watchdog: got no completion within time limit expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
